sn_decoder: RTL and testbench

SN_DECODER -- requirements
Module: sn_decoder

---
 rtl/sn_pkg.sv | 12 +
 rtl/sn_lane_counter.sv | 23 ++
 rtl/sn_decoder.sv | 94 +++++++++
 tb/tb_sn_decoder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sn_pkg.sv
// rtl/sn_pkg.sv - shared defaults and FSM state type for the stochastic-number decoder
package sn_pkg;
  localparam int SN_N_LANE = 4;
  localparam int SN_BW     = 4;
  localparam int SN_WINDOW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } sn_state_t;
endpackage

// File: rtl/sn_lane_counter.sv
// rtl/sn_lane_counter.sv - per-lane ones counter; clear has priority over enable
module sn_lane_counter #(
  parameter int CW = 5
) (
  input  logic          i_clk_fsm_mux,
  input  logic          i_rst_fsm_mux,
  input  logic          clear,
  input  logic          enable,
  input  logic          bit_in,
  output logic [CW-1:0] count
);

  always_ff @(posedge i_clk_fsm_mux or posedge i_rst_fsm_mux) begin
    if (i_rst_fsm_mux) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && bit_in) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/sn_decoder.sv
// rtl/sn_decoder.sv - stochastic-to-binary decoder: counts ones per lane over a fixed window
module sn_decoder
  import sn_pkg::*;
#(
  parameter int N_LANE = SN_N_LANE,
  parameter int BW     = SN_BW,
  parameter int WINDOW = SN_WINDOW
) (
  input  logic              i_clk_fsm_mux,
  input  logic              i_rst_fsm_mux,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_sn_bit [N_LANE],
  output logic              o_busy,
  output logic              o_valid,
  output logic [BW-1:0]     o_x_bn   [N_LANE],
  output logic [N_LANE-1:0] o_sat
);

  localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [BW:0] MAX_X = (BW+1)'((1 << BW) - 1);

  sn_state_t   state;
  logic [CW-1:0] win_cnt;
  logic        last_sample;
  logic        acc_clr;
  logic        acc_en;
  logic [BW:0] acc   [N_LANE];
  logic [BW:0] final_sum [N_LANE];

  assign last_sample = (win_cnt == CW'(WINDOW - 1));
  // DONE always clears so a back-to-back window starts from zero
  assign acc_clr     = ((state == IDLE) && i_start) || (state == DONE);
  assign acc_en      = (state == ACC) && !i_stop;
  assign o_busy      = (state == ACC);

  for (genvar k = 0; k < N_LANE; k++) begin : g_lane
    sn_lane_counter #(.CW(BW + 1)) u_cnt (
      .i_clk_fsm_mux (i_clk_fsm_mux),
      .i_rst_fsm_mux (i_rst_fsm_mux),
      .clear         (acc_clr),
      .enable        (acc_en),
      .bit_in        (i_sn_bit[k]),
      .count         (acc[k])
    );
  end

  // The final sample lands in the same edge that loads the result
  always_comb begin
    for (int k = 0; k < N_LANE; k++) begin
      final_sum[k] = acc[k] + (BW+1)'(i_sn_bit[k]);
    end
  end

  always_ff @(posedge i_clk_fsm_mux or posedge i_rst_fsm_mux) begin
    if (i_rst_fsm_mux) begin
      state   <= IDLE;
      win_cnt <= '0;
      o_valid <= 1'b0;
      o_sat   <= '0;
      for (int k = 0; k < N_LANE; k++) o_x_bn[k] <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state   <= ACC;
            win_cnt <= '0;
          end
        end
        ACC: begin
          if (i_stop) begin
            state <= IDLE;
          end else if (last_sample) begin
            state   <= DONE;
            o_valid <= 1'b1;
            for (int k = 0; k < N_LANE; k++) begin
              o_sat[k]  <= (final_sum[k] > MAX_X);
              o_x_bn[k] <= (final_sum[k] > MAX_X) ? {BW{1'b1}} : final_sum[k][BW-1:0];
            end
          end else begin
            win_cnt <= win_cnt + CW'(1);
          end
        end
        DONE: begin
          win_cnt <= '0;
          state   <= i_start ? ACC : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sn_decoder.sv
// tb/tb_sn_decoder.sv - directed self-checking bench for sn_decoder
module tb_sn_decoder;
  localparam int NL = 4;
  localparam int BW = 4;
  localparam int W  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic          sn_bit [NL];
  logic          busy;
  logic          valid;
  logic [BW-1:0] x_bn [NL];
  logic [NL-1:0] sat;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int vals [NL];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sn_decoder #(.N_LANE(NL), .BW(BW), .WINDOW(W)) dut (
    .i_clk_fsm_mux (clk),
    .i_rst_fsm_mux (rst),
    .i_start       (start),
    .i_stop        (stop),
    .i_sn_bit      (sn_bit),
    .o_busy        (busy),
    .o_valid       (valid),
    .o_x_bn        (x_bn),
    .o_sat         (sat)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Thermometer-coded encoder model: lane k emits a 1 for the first vals[k] samples
  task automatic set_bits(input int t);
    for (int k = 0; k < NL; k++) sn_bit[k] = (t < vals[k]);
  endtask

  task automatic check_outs(input string tag, input int e0, e1, e2, e3, input logic [NL-1:0] esat);
    check({tag, "_x0"}, 32'(x_bn[0]), 32'(e0));
    check({tag, "_x1"}, 32'(x_bn[1]), 32'(e1));
    check({tag, "_x2"}, 32'(x_bn[2]), 32'(e2));
    check({tag, "_x3"}, 32'(x_bn[3]), 32'(e3));
    check({tag, "_sat"}, 32'(sat), 32'(esat));
  endtask

  // Drives the 16 sample cycles after a start edge; ends in the expected DONE cycle
  task automatic samples(input int restart_t, input int stop_t, output int early_valid);
    early_valid = 0;
    for (int t = 0; t < W; t++) begin
      set_bits(t);
      start = (t == restart_t);
      stop  = (t == stop_t);
      tick();
      if (t == stop_t) begin
        stop = 1'b0;
        break;
      end
      if (t < W - 1) early_valid += int'(valid);
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic window(input int restart_t, input int stop_t, input logic stop_with_start,
                        output int early_valid, output int lat);
    int t0;
    t0    = cyc;
    start = 1'b1;
    stop  = stop_with_start;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    samples(restart_t, stop_t, early_valid);
    lat = cyc - t0;
  endtask

  initial begin
    int ev;
    int lat;
    int t_first;
    int nv;

    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    for (int k = 0; k < NL; k++) sn_bit[k] = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(valid), 0);
    check_outs("rst", 0, 0, 0, 0, 4'b0000);
    rst = 1'b0;
    tick();

    // Loopback with stop held alongside start in IDLE: stop must be ignored
    vals = '{10, 0, 15, 7};
    window(-1, -1, 1'b1, ev, lat);
    check("loop_early_valid", 32'(ev), 0);
    check("loop_latency", 32'(lat), 17);
    check("loop_valid", 32'(valid), 1);
    check_outs("loop", 10, 0, 15, 7, 4'b0000);
    tick();
    check("loop_valid_pulse", 32'(valid), 0);
    check("loop_idle_busy", 32'(busy), 0);
    check_outs("loop_hold", 10, 0, 15, 7, 4'b0000);

    vals = '{16, 16, 16, 16};
    window(-1, -1, 1'b0, ev, lat);
    check("ones_valid", 32'(valid), 1);
    check_outs("ones", 15, 15, 15, 15, 4'b1111);
    tick();

    vals = '{3, 3, 3, 3};
    window(-1, -1, 1'b0, ev, lat);
    check("three_valid", 32'(valid), 1);
    check_outs("three", 3, 3, 3, 3, 4'b0000);
    tick();

    // Abort with stop at window count 7
    vals = '{16, 16, 16, 16};
    window(-1, 7, 1'b0, ev, lat);
    check("abort_busy", 32'(busy), 0);
    check("abort_valid", 32'(valid), 0);
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      nv += int'(valid);
    end
    check("abort_no_valid", 32'(nv), 0);
    check_outs("abort_hold", 3, 3, 3, 3, 4'b0000);

    // Back-to-back: restart in DONE, lane 0 constant 1
    vals = '{16, 6, 0, 0};
    window(-1, -1, 1'b0, ev, lat);
    check("b2b1_valid", 32'(valid), 1);
    check_outs("b2b1", 15, 6, 0, 0, 4'b0001);
    t_first = cyc;
    vals  = '{16, 2, 0, 0};
    set_bits(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_busy", 32'(busy), 1);
    check("b2b_valid_drop", 32'(valid), 0);
    samples(-1, -1, ev);
    check("b2b2_early_valid", 32'(ev), 0);
    check("b2b2_valid", 32'(valid), 1);
    check("b2b2_spacing", 32'(cyc - t_first), 17);
    check_outs("b2b2", 15, 2, 0, 0, 4'b0001);
    tick();

    // Reset at window count 9 clears outputs immediately
    vals  = '{16, 16, 16, 16};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 9; t++) begin
      set_bits(t);
      tick();
    end
    check("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_valid", 32'(valid), 0);
    check_outs("mid_rst", 0, 0, 0, 0, 4'b0000);
    tick();
    rst = 1'b0;
    nv  = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      nv += int'(valid);
    end
    check("post_rst_no_valid", 32'(nv), 0);
    check("post_rst_busy", 32'(busy), 0);

    // Start repeated at count 4 is ignored
    vals = '{1, 2, 3, 4};
    window(4, -1, 1'b0, ev, lat);
    check("rstart_early_valid", 32'(ev), 0);
    check("rstart_latency", 32'(lat), 17);
    check("rstart_valid", 32'(valid), 1);
    check_outs("rstart", 1, 2, 3, 4, 4'b0000);
    tick();
    check("rstart_after_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
